// File: rtl/blink_pkg.sv
// Shared definitions for the blink_bank LED channel bank.
package blink_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLINK = 2'd2,
        PULSE = 2'd3
    } mode_t;

    // LED level for a channel given its mode, whether its counter sits at 0,
    // and its blink toggle state.
    function automatic logic led_decode(input mode_t mode, input logic cnt_zero,
                                        input logic tgl);
        logic led;
        case (mode)
            OFF:     led = 1'b0;
            ON:      led = 1'b1;
            BLINK:   led = tgl;
            PULSE:   led = cnt_zero;
            default: led = 1'b0;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/blink_chan.sv
// One LED channel: period counter, mode/period registers, blink toggle and
// registered led/tick outputs.
module blink_chan
    import blink_pkg::*;
#(
    parameter int unsigned CPT_W      = 16,
    parameter int unsigned DEF_PERIOD = 500,
    parameter mode_t       DEF_MODE   = BLINK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_tick,
    input  logic              wr,
    input  logic [MODE_W-1:0] wr_mode,
    input  logic [CPT_W-1:0]  wr_period,
    output logic              led,
    output logic              tick
);

    mode_t            mode_q, mode_n;
    logic [CPT_W-1:0] period_q, period_n;
    logic [CPT_W-1:0] cnt_q, cnt_n;
    logic [CPT_W-1:0] last;
    logic             tgl_q, tgl_n;
    logic             terminal;
    logic             tick_n;
    logic             led_n;

    // Next-state: a write overrides any terminal in the same cycle; the led
    // is decoded from the post-update state so it is valid the cycle after.
    always_comb begin
        mode_n   = mode_q;
        period_n = period_q;
        cnt_n    = cnt_q;
        tgl_n    = tgl_q;
        tick_n   = 1'b0;
        // period 0 behaves as period 1
        last     = (period_q == '0) ? '0 : period_q - CPT_W'(1);
        terminal = base_tick && (cnt_q == last);
        if (wr) begin
            mode_n   = mode_t'(wr_mode);
            period_n = wr_period;
            cnt_n    = '0;
            tgl_n    = 1'b0;
        end else begin
            tick_n = terminal;
            if (base_tick) begin
                cnt_n = terminal ? '0 : cnt_q + CPT_W'(1);
            end
            if (terminal) begin
                tgl_n = ~tgl_q;
            end
        end
        led_n = led_decode(mode_n, (cnt_n == '0), tgl_n);
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= DEF_MODE;
            period_q <= CPT_W'(DEF_PERIOD);
            cnt_q    <= '0;
            tgl_q    <= 1'b0;
            tick     <= 1'b0;
            led      <= led_decode(DEF_MODE, 1'b1, 1'b0);
        end else begin
            mode_q   <= mode_n;
            period_q <= period_n;
            cnt_q    <= cnt_n;
            tgl_q    <= tgl_n;
            tick     <= tick_n;
            led      <= led_n;
        end
    end

endmodule

// File: rtl/blink_bank.sv
// Bank of NCH independent LED blink channels sharing one prescaler and a
// single-port configuration write interface.
module blink_bank
    import blink_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned PRESCALE   = 50_000,
    parameter int unsigned CPT_W      = 16,
    parameter int unsigned DEF_PERIOD = 500,
    parameter mode_t       DEF_MODE   = BLINK
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CPT_W-1:0]  cfg_period,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NCH-1:0]    led_o,
    output logic [NCH-1:0]    tick_o
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] pre_q;
    logic            base_tick;
    logic            ch_valid;
    logic [NCH-1:0]  wr_sel;

    // Base tick on the last prescaler count while enabled.
    always_comb begin
        base_tick = en && (pre_q == PS_W'(PRESCALE - 1));
        ch_valid  = ({1'b0, cfg_ch} < 5'(NCH));
    end

    // Per-channel write select decode.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr_sel[i] = cfg_we && (cfg_ch == 4'(i));
        end
    end

    // Prescaler: frozen while en is low, untouched by writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= base_tick ? '0 : pre_q + PS_W'(1);
        end
    end

    // Write acknowledge / reject pulses, one per write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_we && ch_valid;
            cfg_err <= cfg_we && !ch_valid;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        blink_chan #(
            .CPT_W      (CPT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_MODE   (DEF_MODE)
        ) u_chan (
            .clk        (CLK),
            .rst        (RST),
            .base_tick  (base_tick),
            .wr         (wr_sel[g]),
            .wr_mode    (cfg_mode),
            .wr_period  (cfg_period),
            .led        (led_o[g]),
            .tick       (tick_o[g])
        );
    end

endmodule

// File: tb/tb_blink_bank.sv
// Randomized self-checking bench for blink_bank against a behavioural model.
module tb_blink_bank;
    import blink_pkg::*;

    localparam int NCH = 4;
    localparam int PRESCALE = 2;
    localparam int CPT_W = 8;
    localparam int DEF_PERIOD = 3;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             en = 1'b0;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_ch = '0;
    logic [1:0]       cfg_mode = '0;
    logic [CPT_W-1:0] cfg_period = '0;
    logic             cfg_ack, cfg_err;
    logic [NCH-1:0]   led_o, tick_o;

    int n_vec = 0;
    int n_bad = 0;

    // model state
    int m_pre;
    int m_mode [NCH];
    int m_per  [NCH];
    int m_cnt  [NCH];
    int m_blk  [NCH];
    logic [NCH-1:0] e_led, e_tick;
    logic e_ack, e_err;

    blink_bank #(
        .NCH        (NCH),
        .PRESCALE   (PRESCALE),
        .CPT_W      (CPT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_MODE   (BLINK)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .led_o      (led_o),
        .tick_o     (tick_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    // true if the next edge (with en=1 and no write) ends channel c's period
    function automatic bit next_terminal(input int c);
        return (m_pre == PRESCALE - 1) && (m_cnt[c] == eff(m_per[c]) - 1);
    endfunction

    // Apply one clock with the given inputs, advance the model, compare.
    task automatic step(input bit r, input bit e, input bit w, input int c,
                        input int m, input int p);
        bit bt;
        RST = r; en = e; cfg_we = w; cfg_ch = 4'(c);
        cfg_mode = 2'(m); cfg_period = CPT_W'(p);
        @(posedge CLK);
        if (r) begin
            m_pre = 0;
            e_ack = 0; e_err = 0;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 2; m_per[i] = DEF_PERIOD; m_cnt[i] = 0; m_blk[i] = 0;
                e_tick[i] = 0;
            end
        end else begin
            bt = e && (m_pre == PRESCALE - 1);
            if (e) m_pre = (m_pre + 1) % PRESCALE;
            e_ack = w && (c < NCH);
            e_err = w && (c >= NCH);
            for (int i = 0; i < NCH; i++) begin
                if (w && c == i) begin
                    m_mode[i] = m & 3; m_per[i] = p & 255; m_cnt[i] = 0; m_blk[i] = 0;
                    e_tick[i] = 0;
                end else begin
                    e_tick[i] = bt && (m_cnt[i] == eff(m_per[i]) - 1);
                    if (bt) m_cnt[i] = (m_cnt[i] + 1) % eff(m_per[i]);
                    if (e_tick[i]) m_blk[i] = 1 - m_blk[i];
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            case (m_mode[i])
                0: e_led[i] = 0;
                1: e_led[i] = 1;
                2: e_led[i] = m_blk[i][0];
                default: e_led[i] = (m_cnt[i] == 0);
            endcase
        end
        #1;
        chk("led_o",   32'(led_o),   32'(e_led));
        chk("tick_o",  32'(tick_o),  32'(e_tick));
        chk("cfg_ack", 32'(cfg_ack), 32'(e_ack));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        bit found;
        int first_tick;
        // reset, then check raw reset values against constants
        step(1, 1, 1, 1, 1, 7);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_led",  32'(led_o),  32'(0));
        chk("rst_tick", 32'(tick_o), 32'(0));
        chk("rst_ack",  32'(cfg_ack), 32'(0));

        // default blinking: first tick 6 cycles after release
        first_tick = -1;
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 0, 0, 0, 0);
            if (first_tick < 0 && tick_o[0]) first_tick = k;
        end
        chk("first_tick_cyc", 32'(first_tick), 32'(6));
        idle(12);

        // ch2 PULSE period 4
        step(0, 1, 1, 2, 3, 4);
        chk("pulse_led_now", 32'(led_o[2]), 32'(1));
        idle(20);

        // out-of-range channel
        step(0, 1, 1, 5, 1, 2);
        chk("err_pulse", 32'(cfg_err), 32'(1));
        idle(4);

        // ch0 BLINK period 0
        step(0, 1, 1, 0, 2, 0);
        idle(10);

        // ch1 write on its terminal cycle
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (next_terminal(1)) found = 1;
            else step(0, 1, 0, 0, 0, 0);
        end
        chk("term_found", 32'(found), 32'(1));
        step(0, 1, 1, 1, 2, 3);
        chk("term_no_tick", 32'(tick_o[1]), 32'(0));
        idle(14);

        // back-to-back writes, mixing valid and invalid channels
        step(0, 1, 1, 3, 3, 1);
        step(0, 1, 1, 9, 0, 0);
        step(0, 0, 1, 0, 1, 2);
        step(0, 1, 1, 15, 2, 2);
        idle(6);

        // freeze mid-period, then reset mid-period
        idle(3);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 0);
        idle(3);
        step(1, 1, 1, 2, 1, 5);
        chk("rst2_led", 32'(led_o), 32'(0));
        idle(8);

        // random phase
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
